stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//   Sequencer that owns the min/sec values feeding the 4-digit 7-seg display driver.
//   Debounces the pause and clear buttons, divides fast_clk into a 1 Hz count tick and an adjust tick,
//   and runs a RUN/PAUSED/ADJUST FSM. The min/sec outputs connect directly to the display driver's min/sec inputs.
//   The blank outputs let the display flash the field being adjusted.
// PARAMETERS
//   ONE_HZ_DIV  100_000_000  fast_clk cycles per count tick (1 Hz)
//   ADJ_DIV      50_000_000  fast_clk cycles per adjust tick (2 Hz)
//   DEB_CYC       1_000_000  cycles a synced button level must be stable before it is accepted
// PORTS
//   fast_clk     in   1  system clock; all logic is on posedge
//   rst_n        in   1  asynchronous, active-low reset
//   btn_pause    in   1  raw pause/resume button, active-high, asynchronous
//   btn_clear    in   1  raw clear button, active-high, asynchronous
//   sw_adj       in   1  level switch; 1 = adjust mode requested
//   sw_sel       in   1  adjust field select; 0 = minutes, 1 = seconds
//   min          out  6  minutes, 0..59, registered
//   sec          out  6  seconds, 0..59, registered
//   running      out  1  1 while FSM is in RUN
//   blank_min    out  1  1 = display should blank the minute digits this cycle
//   blank_sec    out  1  1 = display should blank the second digits this cycle
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous):
//     - min=0, sec=0, running=0, blank_*=0
//     - FSM=PAUSED; prescalers, debouncers and synchronizers cleared to 0
//   Buttons:
//     - Each button passes through a 2-flop synchronizer.
//     - Debounced level changes only after the synced value differs from it for DEB_CYC consecutive cycles.
//     - A debounced rising edge produces a 1-cycle pulse (pause_p / clear_p). Release produces nothing.
//   Prescalers:
//     - cnt1 runs 0..ONE_HZ_DIV-1; tick1 is high in the cycle cnt1==ONE_HZ_DIV-1.
//     - cnt1 runs only in RUN. It is reset to 0 on entry to RUN and on clear_p.
//     - cntA runs 0..ADJ_DIV-1 only in ADJUST and is reset on entry to ADJUST; tickA is analogous.
//   FSM (transitions evaluated each cycle; sw_adj has highest priority):
//     - PAUSED: sw_adj=1 -> ADJUST; else pause_p -> RUN.
//     - RUN: sw_adj=1 -> ADJUST; else pause_p -> PAUSED; else tick1 -> increment.
//     - ADJUST: sw_adj=0 -> PAUSED. Otherwise tickA increments the field chosen by sw_sel, sampled that cycle.
//     - pause_p in ADJUST is ignored.
//   Arithmetic:
//     - RUN increment: sec 59 -> 0 with min+1; min 59 and sec 59 -> 00:00 wrap. No overflow flag.
//     - ADJUST increment: selected field only, modulo 60, no carry; the other field holds.
//     - min/sec update one cycle after tick1/tickA is high (registered).
//   Clear:
//     - clear_p forces min=sec=0 in any state; FSM state is unchanged.
//     - clear_p wins over a simultaneous tick1/tickA, so that increment is dropped.
//   Blink:
//     - blink flop toggles on each tickA in ADJUST and is forced to 0 outside ADJUST.
//     - blank_min = ADJUST & blink & ~sw_sel; blank_sec = ADJUST & blink & sw_sel. Both registered.
//   Mid-operation reset returns everything to the reset values above within the same cycle (asynchronous).
// TESTING (sim params: ONE_HZ_DIV=10, ADJ_DIV=5, DEB_CYC=4)
//   1. Release reset, hold btn_pause 1 for 3 cycles -> no pause_p, running stays 0.
//      Hold it for 8 cycles -> running=1 exactly once.
//   2. RUN from 00:00 for 600 cycles -> sec=0, min=1.
//      Preload 59:59 via adjust, then RUN 10 cycles -> 00:00.
//   3. In RUN, pulse btn_pause (debounced) -> running=0; min/sec frozen over 50 further cycles.
//   4. sw_adj=1, sw_sel=1, sec=58 -> after 2 tickA: sec=0, min unchanged; blank_sec toggles every 5 cycles; blank_min=0.
//   5. Assert clear so clear_p coincides with tick1 at 00:09 -> 00:00 next cycle, not 00:10; FSM stays RUN.
//   6. Drop rst_n mid-RUN at 03:27 -> immediately min=0, sec=0, running=0, blank_*=0, FSM PAUSED.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Control inputs and display-facing outputs of the stopwatch sequencer.
interface stopwatch_ctrl_if;
   logic       btn_pause;
   logic       btn_clear;
   logic       sw_adj;
   logic       sw_sel;
   logic [5:0] min;
   logic [5:0] sec;
   logic       running;
   logic       blank_min;
   logic       blank_sec;

   modport master (
      output btn_pause, btn_clear, sw_adj, sw_sel,
      input  min, sec, running, blank_min, blank_sec
   );

   modport slave (
      input  btn_pause, btn_clear, sw_adj, sw_sel,
      output min, sec, running, blank_min, blank_sec
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button debounce, 1 Hz / adjust prescalers, RUN/PAUSED/ADJUST FSM, min/sec registers.
module stopwatch_ctrl #(
   parameter int unsigned ONE_HZ_DIV = 100_000_000,
   parameter int unsigned ADJ_DIV    = 50_000_000,
   parameter int unsigned DEB_CYC    = 1_000_000
) (
   input  logic             fast_clk,
   input  logic             rst_n,
   stopwatch_ctrl_if.slave  bus
);

   localparam int unsigned CNT1_W = (ONE_HZ_DIV > 1) ? $clog2(ONE_HZ_DIV) : 1;
   localparam int unsigned CNTA_W = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
   localparam int unsigned DEB_W  = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

   typedef enum logic [1:0] {ST_PAUSED, ST_RUN, ST_ADJUST} state_e;

   // Index 0 = pause button, index 1 = clear button.
   logic [1:0]       btn_raw;
   logic [1:0]       s1_q, s1_d, s2_q, s2_d, deb_q, deb_d, pulse_q, pulse_d;
   logic [DEB_W-1:0] dcnt_q [2];
   logic [DEB_W-1:0] dcnt_d [2];

   state_e            state_q, state_d;
   logic [CNT1_W-1:0] cnt1_q, cnt1_d;
   logic [CNTA_W-1:0] cnta_q, cnta_d;
   logic [5:0]        min_q, min_d, sec_q, sec_d;
   logic              blink_q, blink_d;
   logic              running_q, running_d;
   logic              blank_min_q, blank_min_d, blank_sec_q, blank_sec_d;
   logic              pause_p, clear_p, tick1, ticka, inc_run, inc_adj;

   function automatic logic [5:0] inc60(input logic [5:0] v);
      return (v == 6'd59) ? 6'd0 : v + 6'd1;
   endfunction

   assign btn_raw = {bus.btn_clear, bus.btn_pause};
   assign pause_p = pulse_q[0];
   assign clear_p = pulse_q[1];

   // Synchronize, debounce and edge-detect both buttons.
   always_comb begin
      s1_d    = btn_raw;
      s2_d    = s1_q;
      deb_d   = deb_q;
      pulse_d = '0;
      for (int i = 0; i < 2; i++) begin
         dcnt_d[i] = '0;
         if (s2_q[i] != deb_q[i]) begin
            if (dcnt_q[i] == DEB_W'(DEB_CYC - 1)) begin
               deb_d[i]   = s2_q[i];
               pulse_d[i] = s2_q[i];
            end else begin
               dcnt_d[i] = dcnt_q[i] + DEB_W'(1);
            end
         end
      end
   end

   // Button front-end registers.
   always_ff @(posedge fast_clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= '0;
         s2_q    <= '0;
         deb_q   <= '0;
         pulse_q <= '0;
         dcnt_q  <= '{default: '0};
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         deb_q   <= deb_d;
         pulse_q <= pulse_d;
         dcnt_q  <= dcnt_d;
      end
   end

   // Next-state, prescalers, time arithmetic and display flags.
   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      sec_d   = sec_q;
      blink_d = blink_q;
      inc_run = 1'b0;
      inc_adj = 1'b0;
      tick1   = (state_q == ST_RUN) && (cnt1_q == CNT1_W'(ONE_HZ_DIV - 1));
      ticka   = (state_q == ST_ADJUST) && (cnta_q == CNTA_W'(ADJ_DIV - 1));

      case (state_q)
         ST_PAUSED: begin
            if (bus.sw_adj)   state_d = ST_ADJUST;
            else if (pause_p) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.sw_adj)   state_d = ST_ADJUST;
            else if (pause_p) state_d = ST_PAUSED;
            else if (tick1)   inc_run = 1'b1;
         end
         ST_ADJUST: begin
            if (!bus.sw_adj) begin
               state_d = ST_PAUSED;
            end else if (ticka) begin
               inc_adj = 1'b1;
               blink_d = ~blink_q;
            end
         end
         default: state_d = ST_PAUSED;
      endcase

      if (inc_run) begin
         sec_d = inc60(sec_q);
         if (sec_q == 6'd59) min_d = inc60(min_q);
      end
      if (inc_adj) begin
         if (bus.sw_sel) sec_d = inc60(sec_q);
         else            min_d = inc60(min_q);
      end
      // Clear overrides any increment this cycle.
      if (clear_p) begin
         min_d = '0;
         sec_d = '0;
      end
      if (state_d != ST_ADJUST) blink_d = 1'b0;

      cnt1_d = '0;
      if ((state_q == ST_RUN) && (state_d == ST_RUN) && !clear_p)
         cnt1_d = tick1 ? '0 : cnt1_q + CNT1_W'(1);
      cnta_d = '0;
      if ((state_q == ST_ADJUST) && (state_d == ST_ADJUST))
         cnta_d = ticka ? '0 : cnta_q + CNTA_W'(1);

      running_d   = (state_d == ST_RUN);
      blank_min_d = (state_d == ST_ADJUST) && blink_d && !bus.sw_sel;
      blank_sec_d = (state_d == ST_ADJUST) && blink_d && bus.sw_sel;
   end

   // Core state registers.
   always_ff @(posedge fast_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_PAUSED;
         cnt1_q      <= '0;
         cnta_q      <= '0;
         min_q       <= '0;
         sec_q       <= '0;
         blink_q     <= 1'b0;
         running_q   <= 1'b0;
         blank_min_q <= 1'b0;
         blank_sec_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt1_q      <= cnt1_d;
         cnta_q      <= cnta_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         blink_q     <= blink_d;
         running_q   <= running_d;
         blank_min_q <= blank_min_d;
         blank_sec_q <= blank_sec_d;
      end
   end

   assign bus.min       = min_q;
   assign bus.sec       = sec_q;
   assign bus.running   = running_q;
   assign bus.blank_min = blank_min_q;
   assign bus.blank_sec = blank_sec_q;

endmodule
